// File: rtl/prescaled_counter_if.sv
// Control and data bundle between a prescaled counter and whatever drives it.
// The master drives enable, direction and load; the slave returns count and pulses.
interface prescaled_counter_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] O;
    logic             TICK;
    logic             TC;

    modport master (
        output CE, UP, LOAD, D,
        input  O, TICK, TC
    );

    modport slave (
        input  CE, UP, LOAD, D,
        output O, TICK, TC
    );
endinterface

// File: rtl/prescaled_counter.sv
// Up/down counter advanced once every DIV enabled cycles by an internal prescaler,
// with synchronous load, optional saturation and combinational tick/terminal-count pulses.
module prescaled_counter #(
    parameter int              WIDTH    = 8,
    parameter int              PW       = 22,
    parameter longint unsigned DIV      = 64'd4194304,
    parameter int              SATURATE = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    prescaled_counter_if.slave bus
);
    localparam logic [PW-1:0] LP_PCNT_LAST = PW'(DIV - 64'd1);

    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_o;

    logic             w_pcnt_last;
    logic             w_tick;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_o_next;

    // With DIV=1 the prescaler is pinned at zero, so the compare is always true.
    assign w_pcnt_last = (r_pcnt == LP_PCNT_LAST);
    assign w_tick      = RESET & ~bus.LOAD & bus.CE & w_pcnt_last;
    assign w_at_bound  = bus.UP ? (r_o == {WIDTH{1'b1}}) : (r_o == {WIDTH{1'b0}});

    assign bus.TICK = w_tick;
    assign bus.TC   = w_tick & w_at_bound;
    assign bus.O    = r_o;

    // NOTE: default assignment first so every path assigns w_o_next and no latch is inferred.
    always_comb begin
        w_o_next = r_o;
        if (!(SATURATE != 0 && w_at_bound)) begin
            w_o_next = bus.UP ? r_o + WIDTH'(1) : r_o - WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_pcnt <= '0;
            r_o    <= '0;
        end else if (bus.LOAD) begin
            r_pcnt <= '0;
            r_o    <= bus.D;
        end else if (bus.CE) begin
            r_pcnt <= w_pcnt_last ? '0 : r_pcnt + PW'(1);
            if (w_tick) begin
                r_o <= w_o_next;
            end
        end
    end
endmodule

// File: tb/tb_prescaled_counter.sv
// Directed vector bench: wrapping and saturating DIV=5 builds share one stimulus table,
// then a DIV=1 build is exercised by a short hand-written sequence.
module tb_prescaled_counter;
    logic       clk;
    logic       rst;
    logic       ce;
    logic       up;
    logic       load;
    logic [3:0] d;

    int n_checks = 0;
    int n_fails  = 0;

    prescaled_counter_if #(.WIDTH(4)) if_a ();
    prescaled_counter_if #(.WIDTH(4)) if_s ();
    prescaled_counter_if #(.WIDTH(4)) if_1 ();

    assign if_a.CE = ce;  assign if_a.UP = up;  assign if_a.LOAD = load;  assign if_a.D = d;
    assign if_s.CE = ce;  assign if_s.UP = up;  assign if_s.LOAD = load;  assign if_s.D = d;
    assign if_1.CE = ce;  assign if_1.UP = up;  assign if_1.LOAD = load;  assign if_1.D = d;

    prescaled_counter #(.WIDTH(4), .PW(3), .DIV(5), .SATURATE(0)) dut_a (
        .CLK(clk), .RESET(rst), .bus(if_a.slave));
    prescaled_counter #(.WIDTH(4), .PW(3), .DIV(5), .SATURATE(1)) dut_s (
        .CLK(clk), .RESET(rst), .bus(if_s.slave));
    prescaled_counter #(.WIDTH(4), .PW(1), .DIV(1), .SATURATE(0)) dut_1 (
        .CLK(clk), .RESET(rst), .bus(if_1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ce, up, load;
        logic [3:0] d;
        logic       tick, tc;    // expected during the cycle (both DIV=5 builds)
        logic [3:0] o_wrap;      // expected O after the edge, SATURATE=0
        logic [3:0] o_sat;       // expected O after the edge, SATURATE=1
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst_i, logic ce_i, logic up_i, logic load_i, logic [3:0] d_i,
                               logic tick_i, logic tc_i, logic [3:0] ow, logic [3:0] os);
        vec_t r;
        r.rst = rst_i; r.ce = ce_i; r.up = up_i; r.load = load_i; r.d = d_i;
        r.tick = tick_i; r.tc = tc_i; r.o_wrap = ow; r.o_sat = os;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst_i, logic ce_i, logic up_i, logic load_i, logic [3:0] d_i);
        @(negedge clk);
        rst = rst_i; ce = ce_i; up = up_i; load = load_i; d = d_i;
        #1;
    endtask

    task automatic check_d1(string tag, logic tick_e, logic tc_e, logic [3:0] o_e);
        check({tag, " d1 tick"}, 32'(if_1.TICK), 32'(tick_e));
        check({tag, " d1 tc"},   32'(if_1.TC),   32'(tc_e));
        @(posedge clk); #1;
        check({tag, " d1 o"},    32'(if_1.O),    32'(o_e));
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; up = 1'b1; load = 1'b0; d = '0;

        // Reset with a coincident load request, then idle in reset.
        vecs.push_back(v(0,1,1,1,4'd7, 0,0, 0,0));
        vecs.push_back(v(0,0,1,0,4'd0, 0,0, 0,0));
        // 20 enabled up cycles: ticks on cycles 5,10,15,20, O steps 1..4.
        for (int k = 1; k <= 20; k++)
            vecs.push_back(v(1,1,1,0,4'd0, (k % 5 == 0), 0, 4'(k / 5), 4'(k / 5)));
        // Prescaler to 3, freeze 7 cycles with UP wiggling, then resume.
        for (int k = 0; k < 3; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 4,4));
        for (int k = 0; k < 7; k++) vecs.push_back(v(1,0,k[0],0,4'd0, 0,0, 4,4));
        vecs.push_back(v(1,1,1,0,4'd0, 0,0, 4,4));
        vecs.push_back(v(1,1,1,0,4'd0, 1,0, 5,5));
        // UP=0 between ticks has no effect; only the tick-cycle direction counts.
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,0,0,4'd0, 0,0, 5,5));
        vecs.push_back(v(1,1,1,0,4'd0, 1,0, 6,6));
        // Load 9 exactly where a tick would fire: tick discarded, prescaler restarts.
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 6,6));
        vecs.push_back(v(1,1,1,1,4'd9, 0,0, 9,9));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 9,9));
        vecs.push_back(v(1,1,1,0,4'd0, 1,0, 10,10));
        // Up at the top boundary: wrap vs hold.
        vecs.push_back(v(1,1,1,1,4'd15, 0,0, 15,15));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 15,15));
        vecs.push_back(v(1,1,1,0,4'd0, 1,1, 0,15));
        // Down at the bottom boundary: wrap vs hold.
        vecs.push_back(v(1,1,0,1,4'd0, 0,0, 0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,0,0,4'd0, 0,0, 0,0));
        vecs.push_back(v(1,1,0,0,4'd0, 1,1, 15,0));
        // Ordinary decrement, then a load with CE low.
        vecs.push_back(v(1,1,0,1,4'd3, 0,0, 3,3));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,0,0,4'd0, 0,0, 3,3));
        vecs.push_back(v(1,1,0,0,4'd0, 1,0, 2,2));
        vecs.push_back(v(1,0,1,1,4'd12, 0,0, 12,12));
        // Reset mid-count at O=15, PCNT=4 with load pending: no tick/tc, all cleared.
        vecs.push_back(v(1,1,1,1,4'd15, 0,0, 15,15));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 15,15));
        vecs.push_back(v(0,1,1,1,4'd7, 0,0, 0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1,1,1,0,4'd0, 0,0, 0,0));
        vecs.push_back(v(1,1,1,0,4'd0, 1,0, 1,1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ce, vecs[i].up, vecs[i].load, vecs[i].d);
            check($sformatf("v%0d tick", i),    32'(if_a.TICK), 32'(vecs[i].tick));
            check($sformatf("v%0d tc", i),      32'(if_a.TC),   32'(vecs[i].tc));
            check($sformatf("v%0d sat tick", i), 32'(if_s.TICK), 32'(vecs[i].tick));
            check($sformatf("v%0d sat tc", i),  32'(if_s.TC),   32'(vecs[i].tc));
            @(posedge clk); #1;
            check($sformatf("v%0d o", i),       32'(if_a.O),    32'(vecs[i].o_wrap));
            check($sformatf("v%0d sat o", i),   32'(if_s.O),    32'(vecs[i].o_sat));
        end

        // DIV=1 build: every enabled, non-load cycle is a tick.
        drive(0,1,1,0,4'd0);  check_d1("rst",   0,0, 4'd0);
        drive(1,1,1,0,4'd0);  check_d1("c1",    1,0, 4'd1);
        drive(1,1,1,0,4'd0);  check_d1("c2",    1,0, 4'd2);
        drive(1,1,1,0,4'd0);  check_d1("c3",    1,0, 4'd3);
        drive(1,0,1,0,4'd0);  check_d1("hold",  0,0, 4'd3);
        drive(1,1,0,0,4'd0);  check_d1("down",  1,0, 4'd2);
        drive(1,1,1,1,4'd15); check_d1("load",  0,0, 4'd15);
        drive(1,1,1,0,4'd0);  check_d1("wrap",  1,1, 4'd0);
        drive(0,1,0,0,4'd0);  check_d1("rst2",  0,0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: main counter width, 1..32.
REQ-002 SHALL have parameter PW, default 22: prescaler register width, 1..32.
REQ-003 SHALL have parameter DIV, default 4194304: prescale divisor, 1..2^PW.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at boundary, 1 = hold at boundary.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port CE, input, 1, enable for the prescaler and counter.
REQ-008 SHALL have port UP, input, 1, count direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port LOAD, input, 1, synchronous load strobe.
REQ-010 SHALL have port D, input, WIDTH, load value.
REQ-011 SHALL have port O, output, WIDTH, registered counter value.
REQ-012 SHALL have port TICK, output, 1, combinational prescaler terminal pulse.
REQ-013 SHALL have port TC, output, 1, combinational counter terminal-count pulse (carry/borrow out).

Function
REQ-014 SHALL hold internal prescaler PCNT[PW-1:0], counting 0..DIV-1 by +1 per CE=1 cycle, returning DIV-1 -> 0.
REQ-015 SHALL drive TICK = RESET & ~LOAD & CE & (PCNT == DIV-1); with DIV=1, TICK = RESET & ~LOAD & CE.
REQ-016 SHALL advance O only in cycles where TICK=1, one step per tick; a value change is visible the cycle after the tick.
REQ-017 SHALL, with UP=1 on a tick, set O <= O+1; at O = 2^WIDTH-1, O <= 0 when SATURATE=0, O holds when SATURATE=1.
REQ-018 SHALL, with UP=0 on a tick, set O <= O-1; at O = 0, O <= 2^WIDTH-1 when SATURATE=0, O holds when SATURATE=1.
REQ-019 SHALL drive TC = TICK & (UP ? O == 2^WIDTH-1 : O == 0), independent of SATURATE.
REQ-020 SHALL sample UP only in tick cycles; a direction change between ticks has no effect on state.
REQ-021 SHALL, while CE=0 and LOAD=0, hold PCNT and O unchanged and drive TICK=TC=0.
REQ-022 SHALL, when LOAD=1 (RESET high), set O <= D and PCNT <= 0 regardless of CE, suppress TICK and TC, and discard any coincident tick.
REQ-023 SHALL apply priority RESET > LOAD > tick count > hold.
REQ-024 SHALL compute all arithmetic modulo 2^WIDTH (counter) and modulo DIV (prescaler), with no width growth.

Reset
REQ-025 SHALL, on a CLK edge with RESET=0, set O=0 and PCNT=0, overriding CE, LOAD and UP.
REQ-026 SHALL force TICK=0 and TC=0 combinationally in any cycle with RESET=0.
REQ-027 SHALL, after RESET returns high with CE=1, produce the first TICK in the DIV-th cycle (PCNT = DIV-1).
REQ-028 SHALL, when RESET is asserted mid-count, discard the partial prescale count, with no TICK or TC in that cycle.

Verification (WIDTH=4, PW=3, DIV=5 unless stated)
REQ-029 SHALL cover: reset, then CE=1 UP=1 for 20 cycles -> TICK in cycles 5,10,15,20; O = 1,2,3,4 after each; TC=0.
REQ-030 SHALL cover: LOAD D=15, then UP=1 CE=1 -> TC=1 on the 5th cycle; O becomes 0 (SATURATE=0) or stays 15 (SATURATE=1).
REQ-031 SHALL cover: O=0, UP=0, tick -> TC=1 and O becomes 15 (SATURATE=0) or stays 0 (SATURATE=1).
REQ-032 SHALL cover: CE=0 for 7 cycles at PCNT=3 -> PCNT and O frozen; the tick occurs 1 cycle after CE re-asserts.
REQ-033 SHALL cover: LOAD D=9 in the same cycle as PCNT=4 with CE=1 -> TICK=0, O=9, PCNT=0, next TICK 5 cycles later.
REQ-034 SHALL cover: RESET=0 with LOAD=1 D=7 at PCNT=4 -> O=0, PCNT=0, TICK=TC=0; DIV=1 build -> TICK every CE cycle.
